// File: rtl/spi_slave_core_if.sv
// Pin bundle between spi_slave_core and its SPI master / user-side driver.
interface spi_slave_core_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  sck;
   logic                  ss;
   logic                  MOSI;
   logic                  MISO;
   logic                  write;
   logic [DATA_WIDTH-1:0] users_write_data;
   logic                  read;
   logic [DATA_WIDTH-1:0] users_read_data;
   logic                  rov_clr;
   logic                  SPIxTBF;
   logic                  SPIxRBF;
   logic                  SPIROV;

   modport slave (
      input  sck, ss, MOSI, write, users_write_data, read, rov_clr,
      output MISO, users_read_data, SPIxTBF, SPIxRBF, SPIROV
   );

   modport master (
      output sck, ss, MOSI, write, users_write_data, read, rov_clr,
      input  MISO, users_read_data, SPIxTBF, SPIxRBF, SPIROV
   );
endinterface

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: DATA_WIDTH-bit MSB-first frames, sck/ss/MOSI oversampled on clk.
// Define SPI_SLAVE_CPHA1_EN for mode 1 (tx shifts on sck rise, MOSI sampled on fall); default is mode 0.
module spi_slave_core #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   spi_slave_core_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
   logic                   sck_s, ss_s, mosi_s;
   logic                   sck_q, ss_q;
   logic                   sck_rise, sck_fall, ss_fall, ss_rise;
   logic                   sample_edge, shift_edge;

   logic [DATA_WIDTH-1:0]  tx_buf, tx_buf_nx;
   logic [DATA_WIDTH-1:0]  tx_shift, tx_shift_nx;
   logic [DATA_WIDTH-1:0]  rx_shift, rx_shift_nx;
   logic [DATA_WIDTH-1:0]  rd_data, rd_data_nx;
   logic [CNT_W-1:0]       bitcnt, bitcnt_nx;
   logic                   tbf, tbf_nx, rbf, rbf_nx, rov, rov_nx, miso, miso_nx;
   logic                   load, done;

   // Synchronizers; ss resets to its idle (high) level so no false frame start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_q     <= 1'b0;
         ss_q      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         sck_q     <= sck_s;
         ss_q      <= ss_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_q;
   assign sck_fall = ~sck_s & sck_q;
   assign ss_fall  = ~ss_s & ss_q;
   assign ss_rise  = ss_s & ~ss_q;

`ifdef SPI_SLAVE_CPHA1_EN
   assign sample_edge = sck_fall;
   assign shift_edge  = sck_rise;
`else
   assign sample_edge = sck_rise;
   assign shift_edge  = sck_fall;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tx_buf   <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rd_data  <= '0;
         bitcnt   <= '0;
         tbf      <= 1'b0;
         rbf      <= 1'b0;
         rov      <= 1'b0;
         miso     <= 1'b0;
      end else begin
         state    <= state_nx;
         tx_buf   <= tx_buf_nx;
         tx_shift <= tx_shift_nx;
         rx_shift <= rx_shift_nx;
         rd_data  <= rd_data_nx;
         bitcnt   <= bitcnt_nx;
         tbf      <= tbf_nx;
         rbf      <= rbf_nx;
         rov      <= rov_nx;
         miso     <= miso_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      tx_buf_nx   = tx_buf;
      tx_shift_nx = tx_shift;
      rx_shift_nx = rx_shift;
      rd_data_nx  = rd_data;
      bitcnt_nx   = bitcnt;
      tbf_nx      = tbf;
      rbf_nx      = rbf;
      rov_nx      = rov;
      load        = 1'b0;
      done        = 1'b0;

      if (bus.rov_clr) rov_nx = 1'b0;
      if (bus.read)    rbf_nx = 1'b0;

      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_nx  = ACTIVE;
               bitcnt_nx = '0;
               load      = 1'b1;
            end
         end
         ACTIVE: begin
            if (bitcnt == CNT_W'(DATA_WIDTH)) begin
               // Completion clk: hand the word over, then reload tx for a back-to-back frame.
               done      = 1'b1;
               bitcnt_nx = '0;
               if (!rbf || bus.read) begin
                  rd_data_nx = rx_shift;
                  rbf_nx     = 1'b1;
               end else begin
                  rov_nx = 1'b1;
               end
               load = ~ss_rise;
            end else begin
               if (sample_edge) begin
                  rx_shift_nx = {rx_shift[DATA_WIDTH-2:0], mosi_s};
                  bitcnt_nx   = bitcnt + CNT_W'(1);
               end
               // No shift before the first sample: the MSB must stay on MISO for bit 0.
               if (shift_edge && bitcnt != '0)
                  tx_shift_nx = {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (ss_rise) begin
               state_nx    = IDLE;
               bitcnt_nx   = '0;
               rx_shift_nx = '0;
               tx_shift_nx = '0;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (load) begin
         tx_shift_nx = tbf ? tx_buf : '0;
         tbf_nx      = 1'b0;
      end
      if (bus.write && !tbf) begin
         tx_buf_nx = bus.users_write_data;
         tbf_nx    = 1'b1;
      end

      miso_nx = (state_nx == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;
   end

   assign bus.MISO            = miso;
   assign bus.users_read_data = rd_data;
   assign bus.SPIxTBF         = tbf;
   assign bus.SPIxRBF         = rbf;
   assign bus.SPIROV          = rov;

   logic unused_done;
   assign unused_done = done;
endmodule
